// File: rtl/hum_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hum_ctrl_pkg
// Shared definitions for the humidity status controller and the VGA humidity
// status panel. The status encodings below are the 2-bit word the panel
// decodes, so they must stay in step with the display side.
// Contents:
//   hum_state_t      - controller state / status word type
//   HUM_IDLE..HUM_ERROR - state and status encodings
//   MAX_HUM_DEFAULT  - largest legal humidity reading (0.1 %RH units)
// -----------------------------------------------------------------------------
package hum_ctrl_pkg;

  typedef logic [1:0] hum_state_t;

  localparam hum_state_t HUM_IDLE       = 2'b00;
  localparam hum_state_t HUM_HUMIDIFY   = 2'b01;
  localparam hum_state_t HUM_DEHUMIDIFY = 2'b10;
  localparam hum_state_t HUM_ERROR      = 2'b11;

  localparam int unsigned MAX_HUM_DEFAULT = 1000;

endpackage

// File: rtl/hum_status_controller_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Saturating down-counter shared by the on-dwell and off-dwell of the humidity
// controller. A load strobe reloads the count; otherwise it counts down by one
// per cycle and holds at zero. Expired means the count is zero.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (count clears to 0)
//   i_load       - reload strobe
//   i_load_val   - value loaded on i_load
//   o_expired    - high while the count is zero
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/hum_status_controller.sv
// -----------------------------------------------------------------------------
// hum_status_controller
// Humidifier/dehumidifier decision logic. Applies hysteresis around a setpoint,
// enforces minimum on/off dwell times and flags sensor faults as the ERROR
// status shown on the VGA humidity panel.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   sample_valid      - one-cycle strobe qualifying humidity/setpoint/band
//   humidity          - measured RH (0.1 %RH)
//   setpoint, band    - target RH and hysteresis half-width (0.1 %RH)
//   status            - 00 idle, 01 humidify, 10 dehumidify, 11 error
//   humidifier_on     - relay drive, high only in HUMIDIFY
//   dehumidifier_on   - relay drive, high only in DEHUMIDIFY
//   fault             - bit0 range fault, bit1 timeout fault (latched in ERROR)
// Build option:
//   HUM_CTRL_WATCHDOG_EN - when defined, a watchdog forces ERROR (fault[1]) if
//   TIMEOUT_CYCLES pass without a sample. When undefined, no watchdog is built
//   and fault[1] stays 0.
// -----------------------------------------------------------------------------
module hum_status_controller
  import hum_ctrl_pkg::*;
#(
  parameter int unsigned HUM_W             = 10,
  parameter int unsigned MAX_HUM           = MAX_HUM_DEFAULT,
  parameter int unsigned MIN_ON_CYCLES     = 50_000_000,
  parameter int unsigned MIN_OFF_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES    = 150_000_000,
  parameter int unsigned ERR_CLEAR_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [HUM_W-1:0] humidity,
  input  logic [HUM_W-1:0] setpoint,
  input  logic [HUM_W-1:0] band,
  output logic [1:0]       status,
  output logic             humidifier_on,
  output logic             dehumidifier_on,
  output logic [1:0]       fault
);

  localparam int unsigned TH_W      = HUM_W + 1;
  localparam int unsigned DWELL_MAX = (MIN_ON_CYCLES > MIN_OFF_CYCLES) ? MIN_ON_CYCLES
                                                                       : MIN_OFF_CYCLES;
  // +1 so the dwell value itself is representable when it is a power of two
  localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);
  localparam int unsigned CLR_W     = $clog2(ERR_CLEAR_SAMPLES + 1);

  localparam logic [TH_W-1:0]    MAX_TH   = TH_W'(MAX_HUM);
  localparam logic [DWELL_W-1:0] ON_LOAD  = DWELL_W'(MIN_ON_CYCLES);
  localparam logic [DWELL_W-1:0] OFF_LOAD = DWELL_W'(MIN_OFF_CYCLES);
  localparam logic [CLR_W-1:0]   CLR_LAST = CLR_W'(ERR_CLEAR_SAMPLES - 1);

  // setpoint - band, clamped at 0 (MSB of the widened difference is the borrow)
  function automatic logic [TH_W-1:0] sat_sub(input logic [HUM_W-1:0] a,
                                               input logic [HUM_W-1:0] b);
    logic [TH_W-1:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[TH_W-1] ? '0 : d;
  endfunction

  // setpoint + band, clamped at MAX_HUM
  function automatic logic [TH_W-1:0] sat_add(input logic [HUM_W-1:0] a,
                                               input logic [HUM_W-1:0] b);
    logic [TH_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > MAX_TH) ? MAX_TH : s;
  endfunction

  hum_state_t        r_state;
  logic [1:0]        r_fault;
  logic [CLR_W-1:0]  r_clr_cnt;

  hum_state_t        w_state_nxt;
  logic [1:0]        w_fault_nxt;
  logic [CLR_W-1:0]  w_clr_nxt;
  logic              w_dwell_load;
  logic [DWELL_W-1:0] w_dwell_val;
  logic              w_dwell_exp;
  logic              w_wd_expire;

  logic [TH_W-1:0]   w_hum_x;
  logic [TH_W-1:0]   w_sp_x;
  logic [TH_W-1:0]   w_lo;
  logic [TH_W-1:0]   w_hi;
  logic              w_range_err;

  assign w_hum_x     = {1'b0, humidity};
  assign w_sp_x      = {1'b0, setpoint};
  assign w_lo        = sat_sub(setpoint, band);
  assign w_hi        = sat_add(setpoint, band);
  assign w_range_err = (w_hum_x > MAX_TH);

`ifdef HUM_CTRL_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;

  // A sample in the expiry cycle takes precedence and restarts the count.
  assign w_wd_expire = !sample_valid && (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (sample_valid || w_wd_expire) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  dwell_timer #(
    .CNT_W (DWELL_W)
  ) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_dwell_load),
    .i_load_val (w_dwell_val),
    .o_expired  (w_dwell_exp)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_fault_nxt  = r_fault;
    w_clr_nxt    = r_clr_cnt;
    w_dwell_load = 1'b0;
    w_dwell_val  = OFF_LOAD;
    if (sample_valid) begin
      if (w_range_err) begin
        w_state_nxt    = HUM_ERROR;
        w_fault_nxt[0] = 1'b1;
        w_clr_nxt      = '0;
      end else begin
        case (r_state)
          HUM_IDLE: begin
            if (w_dwell_exp && (w_hum_x < w_lo)) begin
              w_state_nxt  = HUM_HUMIDIFY;
              w_dwell_load = 1'b1;
              w_dwell_val  = ON_LOAD;
            end else if (w_dwell_exp && (w_hum_x > w_hi)) begin
              w_state_nxt  = HUM_DEHUMIDIFY;
              w_dwell_load = 1'b1;
              w_dwell_val  = ON_LOAD;
            end
          end
          HUM_HUMIDIFY: begin
            if (w_dwell_exp && (w_hum_x >= w_sp_x)) begin
              w_state_nxt  = HUM_IDLE;
              w_dwell_load = 1'b1;
            end
          end
          HUM_DEHUMIDIFY: begin
            if (w_dwell_exp && (w_hum_x <= w_sp_x)) begin
              w_state_nxt  = HUM_IDLE;
              w_dwell_load = 1'b1;
            end
          end
          default: begin
            if (r_clr_cnt == CLR_LAST) begin
              w_state_nxt  = HUM_IDLE;
              w_fault_nxt  = 2'b00;
              w_clr_nxt    = '0;
              w_dwell_load = 1'b1;
            end else begin
              w_clr_nxt = r_clr_cnt + 1'b1;
            end
          end
        endcase
      end
    end else if (w_wd_expire) begin
      // Also taken in ERROR: a repeated timeout restarts the clear sequence.
      w_state_nxt    = HUM_ERROR;
      w_fault_nxt[1] = 1'b1;
      w_clr_nxt      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HUM_IDLE;
      r_fault   <= 2'b00;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_fault   <= w_fault_nxt;
      r_clr_cnt <= w_clr_nxt;
    end
  end

  assign status          = r_state;
  assign humidifier_on   = (r_state == HUM_HUMIDIFY);
  assign dehumidifier_on = (r_state == HUM_DEHUMIDIFY);
  assign fault           = r_fault;

endmodule

// File: doc/hum_status_controller.md
# hum_status_controller

Decides humidifier/dehumidifier operation from periodic relative-humidity samples and produces the 2-bit humidity status word that the VGA humidity status panel renders. It sits between the sensor-reading front end and the actuator relays. It applies hysteresis around a setpoint and enforces minimum on/off dwell times. It also flags sensor faults (out-of-range readings, and optionally missing samples) as the error status.

## Interface
- HUM_W, 10: width of humidity, setpoint and band values (units 0.1 %RH)
- MAX_HUM, 1000: largest legal reading (100.0 %RH)
- MIN_ON_CYCLES, 50_000_000: minimum clk cycles spent in HUMIDIFY/DEHUMIDIFY before returning to IDLE
- MIN_OFF_CYCLES, 100_000_000: minimum clk cycles in IDLE before either actuator may start
- TIMEOUT_CYCLES, 150_000_000: watchdog limit between accepted samples
- ERR_CLEAR_SAMPLES, 3: consecutive in-range samples required to leave ERROR
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_valid  input  1  one-cycle strobe; humidity, setpoint and band are valid this cycle
- humidity  input  HUM_W  measured RH
- setpoint  input  HUM_W  target RH
- band  input  HUM_W  hysteresis half-width
- status  output  2  00 idle, 01 humidifying, 10 dehumidifying, 11 error
- humidifier_on  output  1  relay drive, high only in HUMIDIFY
- dehumidifier_on  output  1  relay drive, high only in DEHUMIDIFY
- fault  output  2  bit0 range fault, bit1 timeout fault; latched while in ERROR

## Operation
- States: IDLE, HUMIDIFY, DEHUMIDIFY, ERROR. status, humidifier_on and dehumidifier_on decode directly from the state register.
- Thresholds are computed in HUM_W+1 bits on each sample:
  - lo = setpoint − band, saturating at 0
  - hi = setpoint + band, saturating at MAX_HUM
- The state machine acts only on a sample_valid cycle, except for the watchdog.
- Range check, highest priority, in any state: humidity > MAX_HUM → ERROR and set fault[0].
- IDLE:
  - humidity < lo and off-dwell expired → HUMIDIFY; load on-dwell.
  - humidity > hi and off-dwell expired → DEHUMIDIFY; load on-dwell.
  - Otherwise stay in IDLE.
- HUMIDIFY: humidity ≥ setpoint and on-dwell expired → IDLE; load off-dwell.
- DEHUMIDIFY: humidity ≤ setpoint and on-dwell expired → IDLE; load off-dwell.
- A direct HUMIDIFY↔DEHUMIDIFY transition never occurs.
- ERROR:
  - Both relays are off.
  - Each in-range sample increments the clear counter.
  - An out-of-range sample zeroes the counter.
  - When the counter reaches ERR_CLEAR_SAMPLES → IDLE; clear fault; load off-dwell.
- One shared dwell down-counter serves both the on-dwell and the off-dwell, which are never active at the same time. It saturates at 0; "expired" means count == 0.
- Setpoint or band changes take effect only on the next sample.

## Timing
- Reset values:
  - state IDLE, status 00, both relays 0, fault 00
  - dwell counter 0, so the first sample may start an actuator
  - watchdog counter 0, clear counter 0
- Latency: a sample accepted in cycle N is reflected in status/relays/fault at cycle N+1 (registered outputs).
- Dwell: after entering an active state at cycle N+1, exit is allowed on any sample arriving at or after cycle N+1+MIN_ON_CYCLES. The same rule applies to off-dwell with MIN_OFF_CYCLES.
- Watchdog (when compiled in):
  - Counts cycles since the last sample_valid.
  - Reaching TIMEOUT_CYCLES → ERROR with fault[1] set at the next cycle.
  - sample_valid in the same cycle as expiry wins: the counter restarts and no timeout occurs.
  - The watchdog keeps running in ERROR; a further timeout zeroes the clear counter.
- rst_n asserted mid-operation: all outputs go to reset values immediately (asynchronous). Relays drop without honouring the dwell.

## Configuration
- HUM_CTRL_WATCHDOG_EN defined: sample watchdog present, and fault[1] is functional.
- Not defined: no watchdog counter is built, fault[1] is tied 0, and ERROR is entered only on range faults.

## Structure
- Shared package hum_ctrl_pkg holds:
  - status encodings HUM_IDLE=2'b00, HUM_HUMIDIFY=2'b01, HUM_DEHUMIDIFY=2'b10, HUM_ERROR=2'b11 (shared with the display panel)
  - the state typedef
  - MAX_HUM default
- One sub-module, dwell_timer: load value, load strobe, expired flag, down-counter width $clog2 of the larger dwell.

## Test plan
Bench parameters: MIN_ON=8, MIN_OFF=4, TIMEOUT=50, ERR_CLEAR=3; setpoint 500, band 30.
- Reset, then sample 450 → next cycle status 01, humidifier_on 1.
- In HUMIDIFY, sample 520 at 3 cycles after entry → stays 01. Resample 520 at 10 cycles → status 00.
- Sample 450 at 2 cycles after returning to IDLE → stays 00 (off-dwell). Resample at 6 cycles → 01.
- Sample 1001 in DEHUMIDIFY → next cycle status 11, both relays 0, fault 01. Then three samples of 500 → status 00, fault 00. Two samples then 1001 → clear counter restarts.
- With HUM_CTRL_WATCHDOG_EN, no sample for 50 cycles → status 11, fault 10. sample_valid exactly on cycle 50 → no error. Without the macro, 200 idle cycles → status stays 00.
- setpoint 10, band 30 → lo saturates at 0, so sample 0 → IDLE. setpoint 990, band 30 → hi = 1000, so sample 1000 → stays IDLE.
